// File: rtl/snoopie_capture_ctrl_pkg.sv
// Shared encodings for the snoopie capture controller: FSM states, record
// field layout and the masked trigger comparison.
package snoopie_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_LOAD    = 3'd4,
        ST_PRESENT = 3'd5,
        ST_WAIT    = 3'd6
    } state_e;

    // Record layout: {timestamp[15:4], probes[3:0]}
    localparam int REC_W   = 16;
    localparam int PROBE_W = 4;
    localparam int TS_LSB  = PROBE_W;
    localparam int TS_W    = REC_W - TS_LSB;

    function automatic logic trigger_match(input logic [PROBE_W-1:0] sample,
                                           input logic [PROBE_W-1:0] mask,
                                           input logic [PROBE_W-1:0] value);
        return ((sample ^ value) & mask) == '0;
    endfunction

endpackage

// File: rtl/snoopie_capture_ctrl_if.sv
// Host readout stream: one captured record per valid/ready handshake.
interface snoopie_capture_ctrl_if;
    import snoopie_capture_ctrl_pkg::*;

    logic [REC_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);

endinterface

// File: rtl/snoopie_capture_ctrl.sv
// Capture sequencer for the snoopie change recorder: arm, trigger, stop short of
// buffer wrap, then drain the recorded words to the host stream.
module snoopie_capture_ctrl
    import snoopie_capture_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2    = 8,
    parameter int FULL_AT       = 254,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_arm,
    input  logic                   cmd_stop,
    input  logic [PROBE_W-1:0]     trigger_mask,
    input  logic [PROBE_W-1:0]     trigger_value,
    input  logic [PROBE_W-1:0]     probes,
    output logic                   snoop_enable,
    input  logic [DEPTH_LOG2-1:0]  snoop_write_address,
    input  logic [REC_W-1:0]       snoop_read_data,
    output logic                   snoop_read_strobe,
    snoopie_capture_ctrl_if.master rd,
    output logic [DEPTH_LOG2-1:0]  record_count,
    output logic [2:0]             state,
    output logic                   busy
);

    localparam int                    SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [DEPTH_LOG2-1:0] FULL_ADDR   = DEPTH_LOG2'(FULL_AT);

    state_e                state_q;
    state_e                state_d;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic                  wait_cnt;
    logic [DEPTH_LOG2-1:0] remaining;
    logic [REC_W-1:0]      rd_data_q;
    logic                  match;
    logic                  settle_done;
    logic                  buffer_full;
    logic                  handshake;

    assign match       = trigger_match(probes, trigger_mask, trigger_value);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign buffer_full = (snoop_write_address >= FULL_ADDR);
    assign handshake   = (state_q == ST_PRESENT) && rd.rd_ready;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (cmd_arm) state_d = ST_ARMED;
            ST_ARMED: begin
                if (cmd_stop)   state_d = ST_IDLE;
                else if (match) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: if (cmd_stop || buffer_full) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (cmd_stop)         state_d = ST_IDLE;
                else if (settle_done) state_d = (snoop_write_address == '0) ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD:    state_d = cmd_stop ? ST_IDLE : ST_PRESENT;
            ST_PRESENT: begin
                if (cmd_stop)       state_d = ST_IDLE;
                else if (handshake) state_d = (remaining == 1) ? ST_IDLE : ST_WAIT;
            end
            // Two cycles: registered read address, then registered RAM output
            ST_WAIT: begin
                if (cmd_stop)      state_d = ST_IDLE;
                else if (wait_cnt) state_d = ST_LOAD;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops enable at once
    always_comb begin
        snoop_enable      = (state_q == ST_CAPTURE);
        snoop_read_strobe = handshake;
        busy              = (state_q != ST_IDLE);
    end

    assign rd.rd_valid = (state_q == ST_PRESENT);
    assign rd.rd_data  = rd_data_q;
    assign state       = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt   <= '0;
            wait_cnt     <= 1'b0;
            remaining    <= '0;
            record_count <= '0;
            rd_data_q    <= '0;
        end else begin
            settle_cnt <= (state_q == ST_SETTLE && !settle_done) ? settle_cnt + 1'b1 : '0;
            wait_cnt   <= (state_q == ST_WAIT) ? ~wait_cnt : 1'b0;
            if (state_q == ST_SETTLE && settle_done && !cmd_stop) begin
                record_count <= snoop_write_address;
                remaining    <= snoop_write_address;
            end else if (handshake) begin
                remaining <= remaining - 1'b1;
            end
            if (state_q == ST_LOAD) rd_data_q <= snoop_read_data;
        end
    end

endmodule

// File: tb/tb_snoopie_capture_ctrl.sv
// Directed bench for snoopie_capture_ctrl with a behavioural snoopie recorder
// and a per-cycle stream monitor.
module tb_snoopie_capture_ctrl;
    import snoopie_capture_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_arm = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [3:0]  trigger_mask = 4'h0;
    logic [3:0]  trigger_value = 4'h0;
    logic [3:0]  probes = 4'h0;
    logic        snoop_enable;
    logic        snoop_read_strobe;
    logic [7:0]  record_count;
    logic [2:0]  state;
    logic        busy;

    // Behavioural snoopie: records {timestamp, probes} on each probe change
    logic [15:0] snoop_mem [256];
    logic [7:0]  sn_waddr = 8'd0;
    logic [7:0]  sn_raddr = 8'd0;
    logic [11:0] sn_ts = 12'd0;
    logic [3:0]  sn_last = 4'h0;
    logic        sn_en_d = 1'b0;
    logic [15:0] sn_read_data = 16'h0;

    snoopie_capture_ctrl_if rd_if ();

    snoopie_capture_ctrl #(.DEPTH_LOG2(8), .FULL_AT(254), .SETTLE_CYCLES(2)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cmd_arm             (cmd_arm),
        .cmd_stop            (cmd_stop),
        .trigger_mask        (trigger_mask),
        .trigger_value       (trigger_value),
        .probes              (probes),
        .snoop_enable        (snoop_enable),
        .snoop_write_address (sn_waddr),
        .snoop_read_data     (sn_read_data),
        .snoop_read_strobe   (snoop_read_strobe),
        .rd                  (rd_if.master),
        .record_count        (record_count),
        .state               (state),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sn_en_d      <= snoop_enable;
        sn_last      <= probes;
        sn_ts        <= sn_ts + 12'd1;
        sn_read_data <= snoop_mem[sn_raddr];
        if (snoop_enable && !sn_en_d) begin
            sn_waddr <= 8'd0;
            sn_raddr <= 8'd0;
            sn_ts    <= 12'd0;
        end else begin
            if (snoop_enable && probes != sn_last) begin
                snoop_mem[sn_waddr] <= {sn_ts, probes};
                sn_waddr            <= sn_waddr + 8'd1;
            end
            if (snoop_read_strobe) sn_raddr <= sn_raddr + 8'd1;
        end
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] got_q [$];
    logic [3:0]  applied_q [$];
    int          hs_idx = 0;
    int          strobe_cnt = 0;
    int          en_rises = 0;
    int          valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        cmd_arm = 1'b1;
        tick(1);
        cmd_arm = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rd_if.rd_valid && n < 50) begin
            tick(1);
            n++;
        end
        check(name, rd_if.rd_valid, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        rd_if.rd_ready = 1'b1;
        while (state != 3'd0 && n < 3000) begin
            tick(1);
            n++;
        end
        rd_if.rd_ready = 1'b0;
        check(name, state, 3'd0);
    endtask

    task automatic check_words(input string name);
        check({name, "_count"}, got_q.size(), applied_q.size());
        for (int i = 0; i < got_q.size() && i < applied_q.size(); i++)
            check({name, "_probes"}, got_q[i][3:0], applied_q[i]);
    endtask

    // Immediate-trigger capture of n incrementing probe changes, then stop
    task automatic run_capture(input int n);
        applied_q.delete();
        trigger_mask  = 4'h0;
        trigger_value = 4'h0;
        pulse_arm();
        tick(1);
        for (int i = 0; i < n; i++) begin
            tick(3);
            probes = probes + 4'd1;
            applied_q.push_back(probes);
        end
        tick(3);
        pulse_stop();
        check("capture_to_settle", state, 3'd3);
    endtask

    // Stream monitor: handshake rules, data vs buffer, hold and return timing
    initial begin : monitor
        logic        prev_valid = 1'b0;
        logic        prev_hs = 1'b0;
        logic        prev_stop = 1'b0;
        logic        prev_en = 1'b0;
        logic [15:0] prev_data = 16'h0;
        int          ret_cnt = 0;
        logic        hs;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0; prev_hs = 1'b0; prev_stop = 1'b0; prev_en = 1'b0; ret_cnt = 0;
            end else begin
                hs = rd_if.rd_valid && rd_if.rd_ready;
                if (snoop_enable && !prev_en) begin
                    got_q.delete();
                    hs_idx = 0;
                    strobe_cnt = 0;
                    en_rises++;
                end
                if (rd_if.rd_valid) valid_cycles++;
                check("busy_decode", busy, state != 3'd0);
                if (rd_if.rd_valid || snoop_read_strobe)
                    check("strobe_is_handshake", snoop_read_strobe, hs);
                if (prev_valid && !prev_hs && !prev_stop) begin
                    check("valid_held", rd_if.rd_valid, 1'b1);
                    check("data_held", rd_if.rd_data, prev_data);
                end
                if (ret_cnt > 0) begin
                    if (cmd_stop) ret_cnt = 0;
                    else if (ret_cnt < 4) begin
                        check("valid_gap", rd_if.rd_valid, 1'b0);
                        ret_cnt++;
                    end else begin
                        check("valid_return", rd_if.rd_valid, 1'b1);
                        ret_cnt = 0;
                    end
                end
                if (hs) begin
                    strobe_cnt++;
                    got_q.push_back(rd_if.rd_data);
                    check("word_vs_buffer", rd_if.rd_data, snoop_mem[hs_idx[7:0]]);
                    hs_idx++;
                    check("strobes_within_count", hs_idx <= int'(record_count), 1'b1);
                    if (hs_idx < int'(record_count) && !cmd_stop) ret_cnt = 1;
                end
                prev_valid = rd_if.rd_valid;
                prev_hs    = hs;
                prev_stop  = cmd_stop;
                prev_en    = snoop_enable;
                prev_data  = rd_if.rd_data;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          c;
        int          er;
        int          vc;
        logic [15:0] w;
        logic [7:0]  last_w;
        rd_if.rd_ready = 1'b0;

        // Reset values
        tick(2);
        check("rst_state", state, 3'd0);
        check("rst_enable", snoop_enable, 1'b0);
        check("rst_strobe", snoop_read_strobe, 1'b0);
        check("rst_valid", rd_if.rd_valid, 1'b0);
        check("rst_data", rd_if.rd_data, 16'h0);
        check("rst_count", record_count, 8'd0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // Trigger on probe[0] rising, three recorded changes, host stop
        applied_q.delete();
        trigger_mask  = 4'b0001;
        trigger_value = 4'b0001;
        probes        = 4'h0;
        pulse_arm();
        check("t1_armed", state, 3'd1);
        tick(2);
        check("t1_no_match_enable", snoop_enable, 1'b0);
        probes = 4'h1;
        check("t1_trigger_cycle_enable", snoop_enable, 1'b0);
        tick(1);
        check("t1_capture_state", state, 3'd2);
        check("t1_enable_after_trigger", snoop_enable, 1'b1);
        foreach (applied_q[i]) applied_q.delete(i);
        tick(10); probes = 4'h3; applied_q.push_back(4'h3);
        tick(10); probes = 4'h2; applied_q.push_back(4'h2);
        tick(10); probes = 4'h6; applied_q.push_back(4'h6);
        tick(10);
        pulse_stop();
        check("t1_enable_after_stop", snoop_enable, 1'b0);
        tick(2);
        check("t1_record_count", record_count, 8'd3);
        drain("t1_drain_idle");
        check_words("t1_words");
        check("t1_word0", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h0093);
        check("t1_word1", got_q.size() > 1 ? got_q[1] : 16'hxxxx, 16'h0132);
        check("t1_word2", got_q.size() > 2 ? got_q[2] : 16'hxxxx, 16'h01D6);

        // Backpressure: hold ready low for 7 cycles on the first word
        run_capture(2);
        wait_valid("t3_first_valid");
        w = rd_if.rd_data;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("t3_no_strobe_stalled", snoop_read_strobe, 1'b0);
            check("t3_data_stable", rd_if.rd_data, w);
        end
        rd_if.rd_ready = 1'b1;
        #1;
        check("t3_strobe_on_accept", snoop_read_strobe, 1'b1);
        tick(1);
        rd_if.rd_ready = 1'b0;
        c = 1;
        while (!rd_if.rd_valid && c < 20) begin
            tick(1);
            c++;
        end
        check("t3_valid_return_cycles", c, 4);
        check("t3_single_strobe", strobe_cnt, 1);
        drain("t3_drain_idle");
        check_words("t3_words");

        // Empty capture: trigger already matching, stop immediately
        trigger_mask  = 4'b0001;
        trigger_value = 4'b0001;
        probes        = 4'h1;
        pulse_arm();
        tick(1);
        check("t4_capture", state, 3'd2);
        pulse_stop();
        check("t4_settle", state, 3'd3);
        vc = valid_cycles;
        tick(2);
        check("t4_idle", state, 3'd0);
        check("t4_record_count", record_count, 8'd0);
        tick(5);
        check("t4_never_valid", valid_cycles, vc);

        // Abort in ARMED: enable must never rise
        trigger_mask  = 4'b0001;
        trigger_value = 4'b0001;
        probes        = 4'h0;
        er = en_rises;
        pulse_arm();
        check("t5a_armed", state, 3'd1);
        tick(3);
        pulse_stop();
        check("t5a_idle", state, 3'd0);
        check("t5a_no_enable", en_rises, er);

        // Abort in PRESENT on word 2 of 5
        run_capture(5);
        wait_valid("t5b_word1_valid");
        rd_if.rd_ready = 1'b1;
        tick(1);
        rd_if.rd_ready = 1'b0;
        wait_valid("t5b_word2_valid");
        check("t5b_present", state, 3'd5);
        pulse_stop();
        check("t5b_valid_dropped", rd_if.rd_valid, 1'b0);
        check("t5b_idle", state, 3'd0);
        tick(10);
        check("t5b_strobes", strobe_cnt, 1);
        check("t5b_words", got_q.size(), 1);

        // Reset mid-capture; arm during capture is ignored
        trigger_mask = 4'h0;
        pulse_arm();
        tick(1);
        check("t6_capture", state, 3'd2);
        tick(2);
        pulse_arm();
        check("t6_arm_ignored", state, 3'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_enable", snoop_enable, 1'b0);
        check("t6_async_state", state, 3'd0);
        check("t6_async_valid", rd_if.rd_valid, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        check("t6_idle_after_reset", state, 3'd0);

        // Full stop: a change every cycle until the buffer threshold
        trigger_mask = 4'h0;
        probes       = 4'h0;
        pulse_arm();
        tick(1);
        check("t2_capture", state, 3'd2);
        last_w = 8'd0;
        c = 0;
        while (snoop_enable && c < 400) begin
            last_w = sn_waddr;
            probes = probes + 4'd1;
            tick(1);
            c++;
        end
        check("t2_stop_addr", last_w, 8'd254);
        check("t2_settle", state, 3'd3);
        tick(2);
        check("t2_load", state, 3'd4);
        check("t2_record_count", record_count, 8'd255);
        check("t2_final_waddr", sn_waddr, 8'd255);
        check("t2_entry0_intact", snoop_mem[0], 16'h0002);
        drain("t2_drain_idle");
        check("t2_words", got_q.size(), 255);
        check("t2_first_word", got_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h0002);
        check("t2_last_word", got_q.size() > 254 ? got_q[254] : 16'hxxxx, 16'h0FE0);
        check("t2_strobes", strobe_cnt, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
